instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encodes symbolic instruction requests (mnemonic plus register/immediate fields) into 32-bit MIPS words for the supported subset: add, sub, jr, nop, ori, lw, sw, beq, lui, j, jal.
- Streams the encoded words into instruction memory at consecutive word addresses.
- Acts as the program loader and self-test generator ahead of the CPU: the inverse of the instruction decode path.

Parameters:
- DEPTH, 1024, instruction-memory capacity in words; power of two.
- ADDR_W, 10, log2(DEPTH); width of the word counter.
- BASE_ADDR, 32'h0000_3000, byte address of the first written word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; applied on the rising clk edge while 0.
- req_valid  in  1  request present.
- req_ready  out  1  encoder accepts the request this cycle.
- req_mnem  in  4  mnemonic code from the shared package.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  16  immediate / branch offset.
- req_target  in  26  jump target field.
- finish  in  1  end-of-program pulse.
- restart  in  1  leave DONE and clear the counter.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  32  byte address = BASE_ADDR + 4*index.
- im_wdata  out  32  encoded word.
- prog_len  out  ADDR_W+1  number of words written.
- done  out  1  program complete.
- err  out  1  sticky: an illegal mnemonic was seen.

Behaviour:
- Reset values: req_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, prog_len=0, done=0, err=0; state=LOAD; the pending write is discarded.
- States:
  - LOAD: req_ready=1 while words_written + pending < DEPTH.
  - FULL: entered when that sum reaches DEPTH; req_ready=0.
  - DONE: req_ready=0, done=1.
- Transitions:
  - LOAD->FULL on capacity reached.
  - LOAD or FULL -> DONE when finish=1 and no write is pending. If a write is pending, DONE is entered on the cycle after that write.
  - DONE->LOAD on restart=1; prog_len and index cleared, err cleared.
  - restart outside DONE is ignored. finish in DONE is ignored.
- Handshake and latency:
  - Transfer occurs when req_valid && req_ready at an edge.
  - The encoded word appears with im_we=1 during the following cycle, so latency is 1 and throughput is one word per cycle.
  - The index increments on each write; prog_len = index.
- Field formats:
  - R-type: {op=0, rs, rt, rd, shamt=0, funct}. add funct 6'h20, sub 6'h22, jr 6'h08 with rt=rd=0 forced. nop = 32'h0.
  - I-type: {op, rs, rt, imm}. ori 6'h0D, lw 6'h23, sw 6'h2B, beq 6'h04, lui 6'h0F with rs forced 0.
  - J-type: {op, target}. j 6'h02, jal 6'h03.
  - Unused request fields are ignored.
- Illegal mnemonic: the request is accepted but no write occurs, the index is unchanged, and err is set.
- Simultaneous finish and transfer: the request is written, then DONE is entered the next cycle.
- Reset mid-write: the write is suppressed that cycle (im_we=0).

Optional Feature:
- INSTR_ENC_WRAP_EN defined:
  - FULL is never entered.
  - The index wraps modulo DEPTH back to BASE_ADDR.
  - prog_len saturates at DEPTH.
  - An extra output port `wrapped` (1 bit, sticky, cleared by reset and restart) is added.
- Undefined: behaviour as above, with no `wrapped` port.

Decomposition:
- Shared package instr_pkg holds:
  - The mnemonic enum: NOP=0, ADD, SUB, JR, ORI, LW, SW, BEQ, LUI, J, JAL; codes 11..15 are illegal.
  - Opcode and funct localparams.
  - State encodings.
- The controller decode consumes the same opcode/funct constants.
- One sub-module: instr_field_pack, purely combinational, mapping mnemonic + fields -> {word, legal}. The top holds the FSM, counter and output register.

Test Plan:
- After reset, issue ORI rs=0 rt=1 imm=16'h1234, then ADD rs=1 rt=2 rd=3 -> writes 32'h34011234 @32'h3000, then 32'h00221820 @32'h3004 on consecutive cycles; prog_len=2.
- Issue LW rs=5 rt=4 imm=8, BEQ rs=1 rt=2 imm=16'hFFFF, LUI rt=7 imm=16'hABCD with req_rs=9 -> words 32'h8CA40008, 32'h1022FFFF, 32'h3C07ABCD (rs forced to 0).
- Issue JAL target=26'h0C00, then JR rs=31 rt=5 rd=5 -> words 32'h0C000C00, 32'h03E00008.
- Issue mnemonic 4'hE -> no im_we, err=1, prog_len unchanged; a following NOP writes 32'h0 at the next address.
- Build with DEPTH=4 and stream 6 requests -> req_ready=0 after the 4th transfer, last address 32'h300C. With INSTR_ENC_WRAP_EN, the 5th write goes to 32'h3000 and wrapped=1.
- Assert finish together with the 2nd transfer -> that word is written, done=1 the next cycle, prog_len=2. Then restart -> done=0, the next write goes to 32'h3000. Drive reset low during a pending write -> no write occurs and all outputs return to reset values.

Source files
------------

// File: rtl/instr_pkg.sv
// instr_pkg: definitions shared by the instruction encoder and the CPU decode path.
// Contents:
//   mnem_t        - symbolic mnemonic codes (values 11..15 are illegal)
//   OP_* / FN_*   - MIPS opcode and funct field values
//   state_t       - encoder controller states
//   r_word/i_word/j_word - field packers for the three instruction formats
package instr_pkg;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        JR  = 4'd3,
        ORI = 4'd4,
        LW  = 4'd5,
        SW  = 4'd6,
        BEQ = 4'd7,
        LUI = 4'd8,
        J   = 4'd9,
        JAL = 4'd10
    } mnem_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FULL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // R-type: shamt is always zero in the supported subset.
    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: combinational mapping of a symbolic request to a 32-bit MIPS word.
// Ports:
//   mnem   in  4   mnemonic code (instr_pkg::mnem_t values)
//   rs/rt/rd in 5  register fields
//   imm    in  16  immediate / branch offset
//   target in  26  jump target
//   word   out 32  encoded instruction (0 when illegal)
//   legal  out 1   mnemonic is in the supported subset
module instr_field_pack
    import instr_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (mnem_t'(mnem))
            NOP: word = 32'h0;
            ADD: word = r_word(rs, rt, rd, FN_ADD);
            SUB: word = r_word(rs, rt, rd, FN_SUB);
            // jr only uses rs; rt/rd are forced to zero regardless of the request.
            JR:  word = r_word(rs, 5'd0, 5'd0, FN_JR);
            ORI: word = i_word(OP_ORI, rs, rt, imm);
            LW:  word = i_word(OP_LW, rs, rt, imm);
            SW:  word = i_word(OP_SW, rs, rt, imm);
            BEQ: word = i_word(OP_BEQ, rs, rt, imm);
            // lui has no source register; rs is forced to zero.
            LUI: word = i_word(OP_LUI, 5'd0, rt, imm);
            J:   word = j_word(OP_J, target);
            JAL: word = j_word(OP_JAL, target);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts symbolic instruction requests, encodes them and streams the
// words into instruction memory at consecutive word addresses starting at BASE_ADDR.
// Ports:
//   clk, reset (synchronous, active-low)
//   req_valid/req_ready handshake; req_mnem, req_rs/rt/rd, req_imm, req_target fields
//   finish  - end-of-program pulse; restart - leave DONE and clear the counter
//   im_we/im_addr/im_wdata - instruction-memory write port (one cycle after transfer)
//   prog_len - words written; done - program complete; err - sticky illegal mnemonic
//   wrapped  - (only with INSTR_ENC_WRAP_EN) sticky: the write index wrapped past DEPTH
// Build option: define INSTR_ENC_WRAP_EN to let the write index wrap modulo DEPTH
// instead of stopping in FULL.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_mnem,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              finish,
    input  logic              restart,
    output logic              im_we,
    output logic [31:0]       im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   prog_len,
    output logic              done,
`ifdef INSTR_ENC_WRAP_EN
    output logic              wrapped,
`endif
    output logic              err
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int FILL_W = ADDR_W + 2;
    localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(DEPTH);

    state_t              state;
    logic [ADDR_W-1:0]   slot_reg;      // memory index of the next write
    logic [ADDR_W:0]     count_reg;     // committed words (prog_len)
    logic                we_reg;        // a write is pending on the memory port
    logic [31:0]         addr_reg;
    logic [31:0]         wdata_reg;
    logic                err_reg;
    logic                finish_pend;   // finish seen together with a transfer
`ifdef INSTR_ENC_WRAP_EN
    logic                wrapped_reg;
`else
    logic [FILL_W-1:0]   fill_after;
`endif

    logic [31:0]         pack_word;
    logic                pack_legal;
    logic [FILL_W-1:0]   fill;          // committed words plus the pending one
    logic                can_take;
    logic                xfer;
    logic                wr;

    instr_field_pack u_pack (
        .mnem   (req_mnem),
        .rs     (req_rs),
        .rt     (req_rt),
        .rd     (req_rd),
        .imm    (req_imm),
        .target (req_target),
        .word   (pack_word),
        .legal  (pack_legal)
    );

    always_comb begin
        fill = FILL_W'(count_reg) + FILL_W'(we_reg);
`ifdef INSTR_ENC_WRAP_EN
        can_take = (state == ST_LOAD) && !finish_pend;
`else
        can_take = (state == ST_LOAD) && !finish_pend && (fill < DEPTH_F);
`endif
        xfer = req_valid && can_take;
        // Illegal mnemonics are consumed but never reach the memory port.
        wr   = xfer && pack_legal;
`ifndef INSTR_ENC_WRAP_EN
        fill_after = fill + FILL_W'(wr);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_LOAD;
            slot_reg    <= '0;
            count_reg   <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= BASE_ADDR;
            wdata_reg   <= 32'h0;
            err_reg     <= 1'b0;
            finish_pend <= 1'b0;
`ifdef INSTR_ENC_WRAP_EN
            wrapped_reg <= 1'b0;
`endif
        end else begin
            we_reg <= wr;
            if (wr) begin
                addr_reg  <= BASE_ADDR + {{(30-ADDR_W){1'b0}}, slot_reg, 2'b00};
                wdata_reg <= pack_word;
                slot_reg  <= slot_reg + ADDR_W'(1);
            end
            // The word counts as written once its write cycle completes.
            if (we_reg) begin
`ifdef INSTR_ENC_WRAP_EN
                if (FILL_W'(count_reg) != DEPTH_F) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
`else
                count_reg <= count_reg + CNT_W'(1);
`endif
            end
            if (xfer && !pack_legal) begin
                err_reg <= 1'b1;
            end
`ifdef INSTR_ENC_WRAP_EN
            // DEPTH words already written or in flight: this one overwrites slot 0 onwards.
            if (wr && (fill >= DEPTH_F)) begin
                wrapped_reg <= 1'b1;
            end
`endif
            case (state)
                ST_LOAD, ST_FULL: begin
                    if (finish || finish_pend) begin
                        // A word accepted with finish must land before done rises.
                        if (wr) begin
                            finish_pend <= 1'b1;
                        end else begin
                            finish_pend <= 1'b0;
                            state       <= ST_DONE;
                        end
                    end
`ifndef INSTR_ENC_WRAP_EN
                    else if (fill_after >= DEPTH_F) begin
                        state <= ST_FULL;
                    end
`endif
                end
                ST_DONE: begin
                    if (restart) begin
                        state     <= ST_LOAD;
                        slot_reg  <= '0;
                        count_reg <= '0;
                        err_reg   <= 1'b0;
`ifdef INSTR_ENC_WRAP_EN
                        wrapped_reg <= 1'b0;
`endif
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // reset also masks the port combinationally so a write in flight is dropped at once.
    assign req_ready = can_take && reset;
    assign im_we     = we_reg && reset;
    assign im_addr   = addr_reg;
    assign im_wdata  = wdata_reg;
    assign prog_len  = count_reg;
    assign done      = (state == ST_DONE);
    assign err       = err_reg;
`ifdef INSTR_ENC_WRAP_EN
    assign wrapped   = wrapped_reg;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven and randomized checks of instr_encoder against an
// arithmetic reference encoder and a queue of expected memory writes.
// Build option: INSTR_ENC_WRAP_EN selects the wrap-mode expectations for the DEPTH=4 case.
module tb_instr_encoder;
    import instr_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready;
    logic [3:0]  req_mnem;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        finish, restart;
    logic        im_we;
    logic [31:0] im_addr, im_wdata;
    logic [10:0] prog_len;
    logic        done, err;

    logic        s_valid, s_ready, s_tie;
    logic        s_im_we;
    logic [31:0] s_im_addr, s_im_wdata;
    logic [2:0]  s_prog_len;
    logic        s_done, s_err;
`ifdef INSTR_ENC_WRAP_EN
    logic        wrapped, s_wrapped;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [31:0] addr; logic [31:0] word; } wr_t;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] s_addr_q[$];

    int   m_slot, m_count;
    logic m_err;

    typedef struct {
        logic [3:0]  mn;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        legal;
        logic [31:0] word;
    } vec_t;
    vec_t vecs[15];

    instr_encoder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_mnem(req_mnem), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm(req_imm), .req_target(req_target), .finish(finish), .restart(restart),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .prog_len(prog_len),
        .done(done),
`ifdef INSTR_ENC_WRAP_EN
        .wrapped(wrapped),
`endif
        .err(err)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(32'h0000_3000)) dut_s (
        .clk(clk), .reset(reset), .req_valid(s_valid), .req_ready(s_ready),
        .req_mnem(req_mnem), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm(req_imm), .req_target(req_target), .finish(s_tie), .restart(s_tie),
        .im_we(s_im_we), .im_addr(s_im_addr), .im_wdata(s_im_wdata), .prog_len(s_prog_len),
        .done(s_done),
`ifdef INSTR_ENC_WRAP_EN
        .wrapped(s_wrapped),
`endif
        .err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder: fields placed by weight (field value times 2^position).
    function automatic logic [32:0] ref_encode(input int mn, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [15:0] imm, input logic [25:0] tgt);
        logic [31:0] w_op, w_rs, w_rt, w_rd, w;
        logic        ok;
        w_op = 32'h0400_0000; w_rs = 32'h0020_0000; w_rt = 32'h0001_0000; w_rd = 32'h0000_0800;
        ok = 1'b1;
        w  = 32'h0;
        case (mn)
            0:  w = 32'h0;
            1:  w = 32'(rs) * w_rs + 32'(rt) * w_rt + 32'(rd) * w_rd + 32'd32;
            2:  w = 32'(rs) * w_rs + 32'(rt) * w_rt + 32'(rd) * w_rd + 32'd34;
            3:  w = 32'(rs) * w_rs + 32'd8;
            4:  w = 32'd13 * w_op + 32'(rs) * w_rs + 32'(rt) * w_rt + 32'(imm);
            5:  w = 32'd35 * w_op + 32'(rs) * w_rs + 32'(rt) * w_rt + 32'(imm);
            6:  w = 32'd43 * w_op + 32'(rs) * w_rs + 32'(rt) * w_rt + 32'(imm);
            7:  w = 32'd4  * w_op + 32'(rs) * w_rs + 32'(rt) * w_rt + 32'(imm);
            8:  w = 32'd15 * w_op + 32'(rt) * w_rt + 32'(imm);
            9:  w = 32'd2  * w_op + 32'(tgt);
            10: w = 32'd3  * w_op + 32'(tgt);
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    // Main-DUT write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (im_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr, im_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", 64'(im_addr), 64'(mon_e.addr));
                chk("write_data", 64'(im_wdata), 64'(mon_e.word));
            end
        end
        if (s_im_we) s_addr_q.push_back(s_im_addr);
    end

    task automatic model_clear();
        m_slot = 0; m_count = 0; m_err = 1'b0;
    endtask

    // One transfer; returns 1 time unit after the accepting edge.
    task automatic send(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic fin, input logic legal, input logic [31:0] word);
        req_mnem = mn; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_target = tgt;
        req_valid = 1'b1;
        finish = fin;
        chk("req_ready", 64'(req_ready), 64'd1);
        if (legal) begin
            exp_q.push_back({BASE + 32'(4 * m_slot), word});
            m_slot++;
            m_count++;
        end else begin
            m_err = 1'b1;
        end
        $display("send mnem=%0d legal=%0d word=%h fin=%0d", mn, legal, word, fin);
        @(posedge clk); #1;
        req_valid = 1'b0;
        finish = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_im_we", 64'(im_we), 64'd0);
        chk("rst_im_addr", 64'(im_addr), 64'(BASE));
        chk("rst_im_wdata", 64'(im_wdata), 64'd0);
        chk("rst_prog_len", 64'(prog_len), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        idle(1);
        restart = 1'b0;
    endtask

    initial begin
        logic [32:0] r;
        reset = 1'b0; req_valid = 1'b0; finish = 1'b0; restart = 1'b0;
        req_mnem = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;
        s_valid = 1'b0; s_tie = 1'b0;
        model_clear();
        idle(2);
        chk_reset_state();
        reset = 1'b1;
        idle(1);

        // mn, rs, rt, rd, imm, target, legal, expected word
        vecs[0]  = '{ORI,   5'd0,  5'd1,  5'd0,  16'h1234, 26'h0,       1'b1, 32'h3401_1234};
        vecs[1]  = '{ADD,   5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       1'b1, 32'h0022_1820};
        vecs[2]  = '{LW,    5'd5,  5'd4,  5'd0,  16'h0008, 26'h0,       1'b1, 32'h8CA4_0008};
        vecs[3]  = '{BEQ,   5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       1'b1, 32'h1022_FFFF};
        vecs[4]  = '{LUI,   5'd9,  5'd7,  5'd0,  16'hABCD, 26'h0,       1'b1, 32'h3C07_ABCD};
        vecs[5]  = '{JAL,   5'd0,  5'd0,  5'd0,  16'h0,    26'h0C00,    1'b1, 32'h0C00_0C00};
        vecs[6]  = '{JR,    5'd31, 5'd5,  5'd5,  16'h0,    26'h0,       1'b1, 32'h03E0_0008};
        vecs[7]  = '{4'hE,  5'd1,  5'd1,  5'd1,  16'h1111, 26'h1,       1'b0, 32'h0};
        vecs[8]  = '{NOP,   5'd3,  5'd3,  5'd3,  16'hFFFF, 26'h123,     1'b1, 32'h0};
        vecs[9]  = '{SUB,   5'd4,  5'd5,  5'd6,  16'h0,    26'h0,       1'b1, 32'h0085_3022};
        vecs[10] = '{SW,    5'd29, 5'd31, 5'd0,  16'hFFFC, 26'h0,       1'b1, 32'hAFBF_FFFC};
        vecs[11] = '{J,     5'd0,  5'd0,  5'd0,  16'h0,    26'h3FFFFFF, 1'b1, 32'h0BFF_FFFF};
        vecs[12] = '{ORI,   5'd31, 5'd31, 5'd7,  16'hFFFF, 26'h155,     1'b1, 32'h37FF_FFFF};
        vecs[13] = '{4'hB,  5'd2,  5'd2,  5'd2,  16'h2222, 26'h2,       1'b0, 32'h0};
        vecs[14] = '{ADD,   5'd31, 5'd0,  5'd31, 16'hBEEF, 26'h3A5,     1'b1, 32'h03E0_F820};

        for (int i = 0; i < 15; i++) begin
            send(vecs[i].mn, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt,
                 1'b0, vecs[i].legal, vecs[i].word);
            chk("tbl_err", 64'(err), 64'(m_err));
        end
        idle(1);
        chk("tbl_prog_len", 64'(prog_len), 64'(m_count));

        // finish together with a transfer: word lands first, then done.
        send(NOP, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0);
        send(ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b1, 32'h0022_1820);
        chk("fin_done_early", 64'(done), 64'd0);
        idle(1);
        chk("fin_done", 64'(done), 64'd1);
        chk("fin_prog_len", 64'(prog_len), 64'(m_count));
        chk("fin_ready", 64'(req_ready), 64'd0);
        finish = 1'b1;
        idle(1);
        finish = 1'b0;
        chk("done_finish_ignored", 64'(done), 64'd1);
        pulse_restart();
        model_clear();
        chk("rst_done_clr", 64'(done), 64'd0);
        chk("rst_len_clr", 64'(prog_len), 64'd0);
        chk("rst_err_clr", 64'(err), 64'd0);

        send(ORI, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 1'b0, 1'b1, 32'h3401_1234);
        send(ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b1, 32'h0022_1820);
        idle(1);
        chk("fin2_done", 64'(done), 64'd1);
        chk("fin2_prog_len", 64'(prog_len), 64'd2);
        pulse_restart();
        model_clear();

        // Randomized requests with idle gaps, checked against the reference encoder.
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  mn;
            logic [4:0]  rs, rt, rd;
            logic [15:0] imm;
            logic [25:0] tgt;
            mn  = 4'($urandom_range(0, 15));
            rs  = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            imm = 16'($urandom); tgt = 26'($urandom);
            r = ref_encode(int'(mn), rs, rt, rd, imm, tgt);
            send(mn, rs, rt, rd, imm, tgt, 1'b0, r[32], r[31:0]);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        r = ref_encode(15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        send(4'hF, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, r[32], r[31:0]);
        idle(1);
        chk("rnd_prog_len", 64'(prog_len), 64'(m_count));
        chk("rnd_err", 64'(err), 64'(m_err));
        pulse_restart();
        chk("restart_ignored_len", 64'(prog_len), 64'(m_count));
        chk("restart_ignored_err", 64'(err), 64'd1);

        // Reset while a write is on the port: strobe drops at once, then reset values.
        send(ORI, 5'd2, 5'd3, 5'd0, 16'h5A5A, 26'h0, 1'b0, 1'b1, 32'h3443_5A5A);
        reset = 1'b0;
        #1;
        chk("midrst_im_we", 64'(im_we), 64'd0);
        exp_q.delete(exp_q.size() - 1);
        idle(1);
        chk_reset_state();
        reset = 1'b1;
        model_clear();
        idle(1);
        send(J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000123, 1'b0, 1'b1, 32'h0800_0123);
        idle(2);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

        // DEPTH=4 instance: hold req_valid for six cycles.
        req_mnem = ORI; req_rs = 5'd0; req_rt = 5'd2; req_imm = 16'h0042;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
`ifdef INSTR_ENC_WRAP_EN
            chk("small_ready", 64'(s_ready), 64'd1);
`else
            chk("small_ready", 64'(s_ready), (i < 4) ? 64'd1 : 64'd0);
`endif
            $display("small cycle=%0d ready=%0d", i, s_ready);
            idle(1);
        end
        s_valid = 1'b0;
        idle(2);
        chk("small_prog_len", 64'(s_prog_len), 64'd4);
`ifdef INSTR_ENC_WRAP_EN
        chk("small_writes", 64'(s_addr_q.size()), 64'd6);
        if (s_addr_q.size() == 6) begin
            chk("small_addr4", 64'(s_addr_q[3]), 64'h300C);
            chk("small_addr5", 64'(s_addr_q[4]), 64'h3000);
        end
        chk("small_wrapped", 64'(s_wrapped), 64'd1);
        chk("main_wrapped", 64'(wrapped), 64'd0);
`else
        chk("small_writes", 64'(s_addr_q.size()), 64'd4);
        if (s_addr_q.size() == 4) chk("small_last_addr", 64'(s_addr_q[3]), 64'h300C);
        chk("small_full_ready", 64'(s_ready), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
